imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side master for the instruction SRAM. The fetch path only ever reads this SRAM; this block fills it.
- Accepts a valid/ready word stream from a boot source (testbench, UART bridge, debug port).
- Writes each word to consecutive byte addresses starting at a programmable base, with optional read-back verify.
- Holds the CPU core in reset (cpu_hold) until the image is loaded, then releases it.

Parameters:
- ADDR_W, 32, SRAM byte-address width.
- MAX_WORDS, 1024, capacity in 32-bit words; one more word than this is an overflow error.
- VERIFY, 1, 1 = read back and compare every word after writing it; 0 = write only.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- base_addr  in  ADDR_W  load base address; sampled on start; bits [1:0] are forced to 0.
- in_valid  in  1  stream word valid.
- in_ready  out  1  loader can accept a word.
- in_data  in  32  instruction word.
- in_last  in  1  marks the final word of the image.
- MemREAD  out  1  SRAM read enable.
- MemWrite  out  2  SRAM write mode: `WRITE_IDLE or `WRITE_WORD.
- address  out  ADDR_W  SRAM byte address.
- write_data  out  32  SRAM write data.
- read_data  in  32  SRAM read data; valid the cycle after MemREAD is asserted with a stable address.
- busy  out  1  load in progress.
- done  out  1  load completed successfully; sticky until the next start.
- error  out  1  load failed; sticky until the next start.
- err_code  out  2  0 none, 1 verify mismatch, 2 overflow.
- err_addr  out  ADDR_W  address of the failing word.
- word_count  out  $clog2(MAX_WORDS+1)  words committed in the current load.
- cpu_hold  out  1  CPU reset request; 1 while not DONE.

Behaviour:
- Reset (asynchronous, active high) values:
  - in_ready=0, MemREAD=0, MemWrite=`WRITE_IDLE, address=0, write_data=0.
  - busy=0, done=0, error=0, err_code=0, err_addr=0, word_count=0.
  - cpu_hold=1. FSM returns to IDLE.
- Reset mid-load aborts the load immediately. SRAM contents are whatever was already written.
- All outputs are registered. States: IDLE, ACCEPT, WRITE, READ, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR + start: latch base, clear word_count, done, error, err_code and err_addr, set cpu_hold=1, go to ACCEPT.
- start in any other state is ignored.
- ACCEPT:
  - in_ready=1; a word transfers when in_valid && in_ready.
  - On transfer: latch in_data and in_last; address <= base + 4*word_count.
  - If word_count==MAX_WORDS, the word is dropped: err_code=2, err_addr=that address, go to ERROR.
  - Otherwise go to WRITE.
- WRITE:
  - in_ready=0, MemWrite=`WRITE_WORD, write_data=latched word, for exactly one cycle.
  - VERIFY=1: go to READ.
  - VERIFY=0: word_count++, then DONE if the latched last flag is set, else ACCEPT.
- READ: MemREAD=1 for one cycle, MemWrite=`WRITE_IDLE, same address.
- CHECK:
  - Compare read_data with the latched word.
  - Mismatch: err_code=1, err_addr=address, go to ERROR.
  - Match: word_count++, then DONE if last, else ACCEPT.
- DONE: done=1, cpu_hold=0, busy=0.
- ERROR: error=1, cpu_hold stays 1, busy=0.
- busy=1 in ACCEPT, WRITE, READ and CHECK.
- Throughput: one word per 2 cycles (VERIFY=0) or per 4 cycles (VERIFY=1), with in_valid held high.
- MemREAD and MemWrite are never active in the same cycle.
- Address wraps modulo 2^ADDR_W with no error; the overflow check is the only bound.
- in_last on the word that would overflow still raises the overflow error.

Decomposition:
- Add `WRITE_WORD beside `WRITE_IDLE in defines.v. Both are 2 bits: IDLE=2'b00, WORD=2'b11.
- Add to defines.v the state encodings (3-bit, localparam-style defines) and the err_code values.
- The FSM, address/count datapath and compare logic live in one module.
- In benches the loader instantiates nothing; it connects to the existing Sram as the write-port master.
- In the system, a 2:1 mux selects the loader over the fetch path while cpu_hold=1.

Test Plan:
- VERIFY=1, base=0x100, stream 0x11111111, 0x22222222, 0x33333333 (last) → writes at 0x100/0x104/0x108, word_count=3, done=1, cpu_hold falls, 12 cycles after the first accept.
- VERIFY=0, 4 words back-to-back → in_ready toggles 1,0 per word, done after 8 cycles, fetch path reads back identical words.
- Bench forces a mismatching read_data on word 2 at base 0 → error=1, err_code=1, err_addr=0x4, word_count=1, cpu_hold stays 1.
- MAX_WORDS=2, send 3 words, last on the third → err_code=2, err_addr=base+8, third word never written (MemWrite idle).
- Assert rst during WRITE of word 1 → all outputs at reset values in the same cycle; a new start reloads correctly from word 0.
- start pulsed while busy, and in_valid high in IDLE → both ignored, in_ready=0, no SRAM activity.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared encodings for the instruction-SRAM loader: SRAM write modes,
// error codes and the loader FSM states.
package imem_loader_pkg;

    // SRAM write-port modes driven on MemWrite.
    localparam logic [1:0] WRITE_IDLE = 2'b00;
    localparam logic [1:0] WRITE_WORD = 2'b11;

    // err_code values.
    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_VERIFY   = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW = 2'd2;

    // Loader states; the encoding is visible on the state_dbg port.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEPT = 3'd1,
        S_WRITE  = 3'd2,
        S_READ   = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    // True while a load is actively moving words.
    function automatic logic is_busy_state(input state_t s);
        return (s == S_ACCEPT) || (s == S_WRITE) || (s == S_READ) || (s == S_CHECK);
    endfunction

    // True in the states where a start pulse begins a new load.
    function automatic logic is_start_state(input state_t s);
        return (s == S_IDLE) || (s == S_DONE) || (s == S_ERROR);
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Write-side master for the instruction SRAM. Takes a valid/ready word
// stream, writes each word to consecutive addresses from a programmable
// base, optionally reads every word back to verify it, and keeps the CPU
// in reset until the whole image has landed.
//
// Stream handshake: a word transfers on a rising edge where in_valid and
// in_ready are both 1. in_ready is only raised in ACCEPT and drops for the
// write (and verify) cycles that follow each transfer; the source may hold
// in_valid/in_data/in_last steady until the transfer happens.
//
// Every output is a flop. The output flops are loaded from the next state,
// so each output always reflects the state the FSM is currently in.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MAX_WORDS = 1024,
    parameter int VERIFY    = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [ADDR_W-1:0]              base_addr,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [31:0]                    in_data,
    input  logic                           in_last,
    output logic                           MemREAD,
    output logic [1:0]                     MemWrite,
    output logic [ADDR_W-1:0]              address,
    output logic [31:0]                    write_data,
    input  logic [31:0]                    read_data,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic [1:0]                     err_code,
    output logic [ADDR_W-1:0]              err_addr,
    output logic [$clog2(MAX_WORDS+1)-1:0] word_count,
    output logic                           cpu_hold,
    output logic [2:0]                     state_dbg
);

    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    // Word addresses are always 4-byte aligned.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WORDS);

    state_t              state_q,      state_d;
    logic [ADDR_W-1:0]   base_q,       base_d;
    logic                last_q,       last_d;
    logic                in_ready_q,   in_ready_d;
    logic                mem_read_q,   mem_read_d;
    logic [1:0]          mem_write_q,  mem_write_d;
    logic [ADDR_W-1:0]   address_q,    address_d;
    logic [31:0]         write_data_q, write_data_d;
    logic                busy_q,       busy_d;
    logic                done_q,       done_d;
    logic                error_q,      error_d;
    logic [1:0]          err_code_q,   err_code_d;
    logic [ADDR_W-1:0]   err_addr_q,   err_addr_d;
    logic [CNT_W-1:0]    word_count_q, word_count_d;
    logic                cpu_hold_q,   cpu_hold_d;

    logic                transfer;
    logic                read_ok;
    logic [ADDR_W-1:0]   next_addr;

    // Handshake, verify compare and the address of the word being accepted.
    always_comb begin
        transfer  = in_valid && in_ready_q;
        read_ok   = (read_data == write_data_q);
        next_addr = base_q + ADDR_W'({word_count_q, 2'b00});
    end

    // Next-state and datapath updates; registered outputs follow the next state.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        last_d       = last_q;
        address_d    = address_q;
        write_data_d = write_data_q;
        err_code_d   = err_code_q;
        err_addr_d   = err_addr_q;
        word_count_d = word_count_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    base_d       = base_addr & ALIGN_MASK;
                    word_count_d = '0;
                    err_code_d   = ERR_NONE;
                    err_addr_d   = '0;
                    state_d      = S_ACCEPT;
                end
            end

            S_ACCEPT: begin
                if (transfer) begin
                    address_d = next_addr;
                    if (word_count_q == CNT_MAX) begin
                        // One word past capacity: drop it and report where it would have gone.
                        err_code_d = ERR_OVERFLOW;
                        err_addr_d = next_addr;
                        state_d    = S_ERROR;
                    end else begin
                        write_data_d = in_data;
                        last_d       = in_last;
                        state_d      = S_WRITE;
                    end
                end
            end

            S_WRITE: begin
                if (VERIFY != 0) begin
                    state_d = S_READ;
                end else begin
                    word_count_d = word_count_q + CNT_W'(1);
                    state_d      = last_q ? S_DONE : S_ACCEPT;
                end
            end

            S_READ: begin
                // The SRAM returns data one cycle after the read strobe.
                state_d = S_CHECK;
            end

            S_CHECK: begin
                if (!read_ok) begin
                    err_code_d = ERR_VERIFY;
                    err_addr_d = address_q;
                    state_d    = S_ERROR;
                end else begin
                    word_count_d = word_count_q + CNT_W'(1);
                    state_d      = last_q ? S_DONE : S_ACCEPT;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d  = (state_d == S_ACCEPT);
        mem_read_d  = (state_d == S_READ);
        mem_write_d = (state_d == S_WRITE) ? WRITE_WORD : WRITE_IDLE;
        busy_d      = is_busy_state(state_d);
        done_d      = (state_d == S_DONE);
        error_d     = (state_d == S_ERROR);
        cpu_hold_d  = (state_d != S_DONE);
    end

    // State and output registers; reset aborts any load in progress at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            last_q       <= 1'b0;
            in_ready_q   <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= WRITE_IDLE;
            address_q    <= '0;
            write_data_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= ERR_NONE;
            err_addr_q   <= '0;
            word_count_q <= '0;
            cpu_hold_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            last_q       <= last_d;
            in_ready_q   <= in_ready_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            address_q    <= address_d;
            write_data_q <= write_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            err_code_q   <= err_code_d;
            err_addr_q   <= err_addr_d;
            word_count_q <= word_count_d;
            cpu_hold_q   <= cpu_hold_d;
        end
    end

    // Port drives straight from the flops.
    always_comb begin
        in_ready   = in_ready_q;
        MemREAD    = mem_read_q;
        MemWrite   = mem_write_q;
        address    = address_q;
        write_data = write_data_q;
        busy       = busy_q;
        done       = done_q;
        error      = error_q;
        err_code   = err_code_q;
        err_addr   = err_addr_q;
        word_count = word_count_q;
        cpu_hold   = cpu_hold_q;
        state_dbg  = state_q;
    end

    // The SRAM port is never asked to read and write in the same cycle.
    a_no_rd_wr: assert property (@(posedge clk) disable iff (rst)
        !(mem_read_q && (mem_write_q != WRITE_IDLE)));

    // The CPU is released exactly when the load has completed.
    a_hold_done: assert property (@(posedge clk) disable iff (rst)
        ((!cpu_hold_q) == done_q));

    // Outcome flags are mutually exclusive.
    a_flags: assert property (@(posedge clk) disable iff (rst)
        !((busy_q && done_q) || (busy_q && error_q) || (done_q && error_q)));

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader. Three loaders share clock and reset:
//   0: VERIFY=1, MAX_WORDS=1024   1: VERIFY=0, MAX_WORDS=1024
//   2: VERIFY=1, MAX_WORDS=2
// Each has its own SRAM model. Every expected SRAM write is queued when the
// word is driven and popped by a monitor when the loader writes.
module tb_imem_loader;

    localparam logic [1:0] WR_IDLE = 2'b00;
    localparam logic [1:0] WR_WORD = 2'b11;
    localparam int W = 66;  // {instance[1:0], address[31:0], data[31:0]}

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [2:0]  start, in_valid, in_last, in_ready, mem_read, busy, done, error, cpu_hold;
    logic [31:0] base_addr [3];
    logic [31:0] in_data [3];
    logic [31:0] address [3];
    logic [31:0] write_data [3];
    logic [31:0] read_data [3];
    logic [31:0] err_addr [3];
    logic [1:0]  mem_write [3];
    logic [1:0]  err_code [3];
    logic [2:0]  state_dbg [3];
    logic [10:0] wc0, wc1;
    logic [1:0]  wc2;
    logic [10:0] wc [3];

    always_comb begin
        wc[0] = wc0;
        wc[1] = wc1;
        wc[2] = {9'd0, wc2};
    end

    imem_loader #(.ADDR_W(32), .MAX_WORDS(1024), .VERIFY(1)) dut_v (
        .clk(clk), .rst(rst), .start(start[0]), .base_addr(base_addr[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_last(in_last[0]),
        .MemREAD(mem_read[0]), .MemWrite(mem_write[0]), .address(address[0]),
        .write_data(write_data[0]), .read_data(read_data[0]), .busy(busy[0]), .done(done[0]),
        .error(error[0]), .err_code(err_code[0]), .err_addr(err_addr[0]), .word_count(wc0),
        .cpu_hold(cpu_hold[0]), .state_dbg(state_dbg[0]));

    imem_loader #(.ADDR_W(32), .MAX_WORDS(1024), .VERIFY(0)) dut_n (
        .clk(clk), .rst(rst), .start(start[1]), .base_addr(base_addr[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_last(in_last[1]),
        .MemREAD(mem_read[1]), .MemWrite(mem_write[1]), .address(address[1]),
        .write_data(write_data[1]), .read_data(read_data[1]), .busy(busy[1]), .done(done[1]),
        .error(error[1]), .err_code(err_code[1]), .err_addr(err_addr[1]), .word_count(wc1),
        .cpu_hold(cpu_hold[1]), .state_dbg(state_dbg[1]));

    imem_loader #(.ADDR_W(32), .MAX_WORDS(2), .VERIFY(1)) dut_s (
        .clk(clk), .rst(rst), .start(start[2]), .base_addr(base_addr[2]),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]), .in_last(in_last[2]),
        .MemREAD(mem_read[2]), .MemWrite(mem_write[2]), .address(address[2]),
        .write_data(write_data[2]), .read_data(read_data[2]), .busy(busy[2]), .done(done[2]),
        .error(error[2]), .err_code(err_code[2]), .err_addr(err_addr[2]), .word_count(wc2),
        .cpu_hold(cpu_hold[2]), .state_dbg(state_dbg[2]));

    // SRAM models: 256 words each, registered read, optional read corruption.
    logic [31:0] mem [3][256];
    logic [2:0]  corrupt_en;
    logic [31:0] corrupt_addr;
    int          rd_seen [3] = '{0, 0, 0};

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (mem_write[i] == WR_WORD) mem[i][address[i][9:2]] <= write_data[i];
            if (mem_read[i]) begin
                rd_seen[i]++;
                read_data[i] <= mem[i][address[i][9:2]] ^
                    ((corrupt_en[i] && address[i] == corrupt_addr) ? 32'h0000_f00d : 32'h0);
            end
        end
    end

    // Scoreboard monitor for SRAM port activity.
    logic [W-1:0] exp_q [$];

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                logic [W-1:0] e;
                if (mem_write[i] != WR_IDLE || mem_read[i]) begin
                    vec_cnt++;
                    if (mem_read[i] && mem_write[i] != WR_IDLE) begin
                        err_cnt++;
                        $display("FAIL rd_wr_overlap inst %0d: MemREAD=1 MemWrite=%b, required never both", i, mem_write[i]);
                    end
                end
                if (mem_write[i] != WR_IDLE) begin
                    vec_cnt++;
                    if (exp_q.size() == 0) begin
                        err_cnt++;
                        $display("FAIL unexpected_write inst %0d: mode %b addr %h data %h, required no write",
                                 i, mem_write[i], address[i], write_data[i]);
                    end else begin
                        e = exp_q.pop_front();
                        if ({2'(i), address[i], write_data[i]} !== e || mem_write[i] !== WR_WORD) begin
                            err_cnt++;
                            $display("FAIL sram_write inst %0d: mode %b addr %h data %h, required inst %0d addr %h data %h",
                                     i, mem_write[i], address[i], write_data[i], e[65:64], e[63:32], e[31:0]);
                        end
                    end
                end
            end
        end
    end

    logic [31:0] words [8];
    int          waits [8];
    int          t_first;
    int          lat;

    function automatic int idx(input logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    // Driver: one-cycle start pulse. Called and returns at posedge+1.
    task automatic pulse_start(input int i, input logic [31:0] b);
        base_addr[i] = b;
        start[i]     = 1'b1;
        @(posedge clk); #1;
        start[i]     = 1'b0;
    endtask

    // Driver: stream words[0..n-1] with valid held high; queues the first n_write writes.
    task automatic stream(input int i, input int n, input int last_idx, input int n_write, input logic [31:0] b);
        int w;
        for (int k = 0; k < n; k++) begin
            in_valid[i] = 1'b1;
            in_data[i]  = words[k];
            in_last[i]  = (k == last_idx);
            if (k < n_write) exp_q.push_back({2'(i), b + 32'(4 * k), words[k]});
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!in_ready[i] && w < 30);
            waits[k] = w;
            if (k == 0) t_first = cyc;
            vec_cnt++;
            if (in_ready[i] !== 1'b1) begin
                err_cnt++;
                $display("FAIL stream_ready inst %0d word %0d: in_ready=%b after %0d cycles, required 1", i, k, in_ready[i], w);
            end
            @(posedge clk); #1;
        end
        in_valid[i] = 1'b0;
        in_last[i]  = 1'b0;
    endtask

    // Waits for done or error; lat is cycles from the first accepting cycle.
    task automatic wait_end(input int i);
        int w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!(done[i] || error[i]) && w < 60);
        lat = cyc - t_first;
        vec_cnt++;
        if (!(done[i] || error[i])) begin
            err_cnt++;
            $display("FAIL wait_end inst %0d: done=%b error=%b after %0d cycles, required one set", i, done[i], error[i], w);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [116:0] got;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        for (int ph = 0; ph < 2; ph++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                got = {in_ready[i], mem_read[i], mem_write[i], address[i], write_data[i], busy[i],
                       done[i], error[i], err_code[i], err_addr[i], wc[i], cpu_hold[i]};
                vec_cnt++;
                if (got !== {1'b0, 1'b0, WR_IDLE, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 11'd0, 1'b1}) begin
                    err_cnt++;
                    $display("FAIL reset_values inst %0d phase %0d: got %h, required %h", i, ph, got, 117'd1);
                end
            end
            @(posedge clk); #1;
            rst = 1'b0;
        end
    endtask

    task automatic test_ignore_idle();
        in_valid[0] = 1'b1;
        in_data[0]  = 32'hbad0_0001;
        in_last[0]  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vec_cnt++;
            if ({in_ready[0], busy[0], mem_read[0], mem_write[0], cpu_hold[0]} !== {3'b000, WR_IDLE, 1'b1}) begin
                err_cnt++;
                $display("FAIL idle_valid cycle %0d: ready=%b busy=%b rd=%b wr=%b hold=%b, required 0 0 0 00 1",
                         c, in_ready[0], busy[0], mem_read[0], mem_write[0], cpu_hold[0]);
            end
        end
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        in_last[0]  = 1'b0;
    endtask

    task automatic test_verify_load();
        words[0] = 32'h1111_1111; words[1] = 32'h2222_2222; words[2] = 32'h3333_3333;
        pulse_start(0, 32'h100);
        vec_cnt++;
        if ({busy[0], in_ready[0], cpu_hold[0], done[0]} !== 4'b1110) begin
            err_cnt++;
            $display("FAIL verify_start: busy/ready/hold/done=%b, required 1110", {busy[0], in_ready[0], cpu_hold[0], done[0]});
        end
        stream(0, 3, 2, 3, 32'h100);
        wait_end(0);
        vec_cnt++;
        if ({done[0], error[0], busy[0], cpu_hold[0], in_ready[0], wc[0]} !== {5'b10000, 11'd3}) begin
            err_cnt++;
            $display("FAIL verify_done: done/err/busy/hold/ready=%b count=%0d, required 10000 count 3",
                     {done[0], error[0], busy[0], cpu_hold[0], in_ready[0]}, wc[0]);
        end
        vec_cnt++;
        if (lat !== 12 || waits[1] !== 4 || waits[2] !== 4) begin
            err_cnt++;
            $display("FAIL verify_timing: latency %0d word gaps %0d %0d, required 12 4 4", lat, waits[1], waits[2]);
        end
        vec_cnt++;
        if ({mem[0][idx(32'h100)], mem[0][idx(32'h104)], mem[0][idx(32'h108)]} !== {words[0], words[1], words[2]}) begin
            err_cnt++;
            $display("FAIL verify_sram: %h %h %h, required %h %h %h", mem[0][idx(32'h100)], mem[0][idx(32'h104)],
                     mem[0][idx(32'h108)], words[0], words[1], words[2]);
        end
    endtask

    task automatic test_mismatch();
        words[0] = 32'haaaa_0001; words[1] = 32'hbbbb_0002;
        corrupt_en[0] = 1'b1;
        corrupt_addr  = 32'h4;
        pulse_start(0, 32'h0);
        vec_cnt++;
        if ({done[0], cpu_hold[0], busy[0]} !== 3'b011) begin
            err_cnt++;
            $display("FAIL restart_from_done: done/hold/busy=%b, required 011", {done[0], cpu_hold[0], busy[0]});
        end
        stream(0, 2, -1, 2, 32'h0);
        wait_end(0);
        corrupt_en[0] = 1'b0;
        vec_cnt++;
        if ({error[0], done[0], busy[0], cpu_hold[0], err_code[0], err_addr[0], wc[0]} !== {4'b1001, 2'd1, 32'h4, 11'd1}) begin
            err_cnt++;
            $display("FAIL mismatch: err/done/busy/hold=%b code %0d addr %h count %0d, required 1001 code 1 addr 4 count 1",
                     {error[0], done[0], busy[0], cpu_hold[0]}, err_code[0], err_addr[0], wc[0]);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [116:0] got;
        mem[0][idx(32'h200)] = 32'h5e17_0000;
        pulse_start(0, 32'h200);
        vec_cnt++;
        if ({error[0], err_code[0], err_addr[0], wc[0], busy[0]} !== {1'b0, 2'd0, 32'h0, 11'd0, 1'b1}) begin
            err_cnt++;
            $display("FAIL restart_from_error: err %b code %0d addr %h count %0d busy %b, required 0 0 0 0 1",
                     error[0], err_code[0], err_addr[0], wc[0], busy[0]);
        end
        in_valid[0] = 1'b1;
        in_data[0]  = 32'hdead_0001;
        in_last[0]  = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        vec_cnt++;
        if (mem_write[0] !== WR_WORD) begin
            err_cnt++;
            $display("FAIL write_phase: MemWrite=%b, required 11", mem_write[0]);
        end
        rst = 1'b1;
        #1;
        got = {in_ready[0], mem_read[0], mem_write[0], address[0], write_data[0], busy[0],
               done[0], error[0], err_code[0], err_addr[0], wc[0], cpu_hold[0]};
        vec_cnt++;
        if (got !== {1'b0, 1'b0, WR_IDLE, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 11'd0, 1'b1}) begin
            err_cnt++;
            $display("FAIL async_reset: got %h, required %h", got, 117'd1);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        vec_cnt++;
        if (mem[0][idx(32'h200)] !== 32'h5e17_0000) begin
            err_cnt++;
            $display("FAIL aborted_write: sram %h, required %h", mem[0][idx(32'h200)], 32'h5e17_0000);
        end
        words[0] = 32'h0a0a_0a0a; words[1] = 32'h0b0b_0b0b;
        pulse_start(0, 32'h200);
        stream(0, 2, 1, 2, 32'h200);
        wait_end(0);
        vec_cnt++;
        if ({done[0], wc[0], mem[0][idx(32'h200)], mem[0][idx(32'h204)]} !== {1'b1, 11'd2, words[0], words[1]}) begin
            err_cnt++;
            $display("FAIL reload: done %b count %0d sram %h %h, required 1 2 %h %h", done[0], wc[0],
                     mem[0][idx(32'h200)], mem[0][idx(32'h204)], words[0], words[1]);
        end
    endtask

    task automatic test_start_while_busy();
        words[0] = 32'h7000_0001; words[1] = 32'h7000_0002;
        pulse_start(0, 32'h80);
        pulse_start(0, 32'h400);
        vec_cnt++;
        if ({busy[0], in_ready[0], wc[0]} !== {2'b11, 11'd0}) begin
            err_cnt++;
            $display("FAIL busy_start: busy %b ready %b count %0d, required 1 1 0", busy[0], in_ready[0], wc[0]);
        end
        stream(0, 2, 1, 2, 32'h80);
        wait_end(0);
        vec_cnt++;
        if ({done[0], wc[0]} !== {1'b1, 11'd2}) begin
            err_cnt++;
            $display("FAIL busy_start_done: done %b count %0d, required 1 2", done[0], wc[0]);
        end
    endtask

    task automatic test_no_verify();
        for (int k = 0; k < 4; k++) words[k] = $urandom();
        pulse_start(1, 32'h301);
        stream(1, 4, 3, 4, 32'h300);
        wait_end(1);
        vec_cnt++;
        if ({done[1], cpu_hold[1], busy[1], wc[1]} !== {3'b100, 11'd4}) begin
            err_cnt++;
            $display("FAIL nv_done: done/hold/busy=%b count %0d, required 100 count 4", {done[1], cpu_hold[1], busy[1]}, wc[1]);
        end
        vec_cnt++;
        if (lat !== 8 || waits[1] !== 2 || waits[2] !== 2 || waits[3] !== 2) begin
            err_cnt++;
            $display("FAIL nv_timing: latency %0d gaps %0d %0d %0d, required 8 2 2 2", lat, waits[1], waits[2], waits[3]);
        end
        for (int k = 0; k < 4; k++) begin
            vec_cnt++;
            if (mem[1][idx(32'h300 + 32'(4 * k))] !== words[k]) begin
                err_cnt++;
                $display("FAIL nv_readback word %0d: %h, required %h", k, mem[1][idx(32'h300 + 32'(4 * k))], words[k]);
            end
        end
    endtask

    task automatic test_wrap();
        words[0] = 32'hface_0000; words[1] = 32'hface_0001;
        pulse_start(1, 32'hffff_fffc);
        stream(1, 2, 1, 2, 32'hffff_fffc);
        wait_end(1);
        vec_cnt++;
        if ({done[1], error[1], wc[1], mem[1][idx(32'h0)]} !== {2'b10, 11'd2, words[1]}) begin
            err_cnt++;
            $display("FAIL wrap: done %b error %b count %0d sram[0] %h, required 1 0 2 %h",
                     done[1], error[1], wc[1], mem[1][idx(32'h0)], words[1]);
        end
    endtask

    task automatic test_overflow();
        words[0] = 32'h0f00_0001; words[1] = 32'h0f00_0002; words[2] = 32'h0f00_0003;
        mem[2][idx(32'h48)] = 32'h5e17_0048;
        pulse_start(2, 32'h40);
        stream(2, 3, 2, 2, 32'h40);
        wait_end(2);
        vec_cnt++;
        if ({error[2], done[2], cpu_hold[2], err_code[2], err_addr[2], wc[2]} !== {3'b101, 2'd2, 32'h48, 11'd2}) begin
            err_cnt++;
            $display("FAIL overflow: err/done/hold=%b code %0d addr %h count %0d, required 101 code 2 addr 48 count 2",
                     {error[2], done[2], cpu_hold[2]}, err_code[2], err_addr[2], wc[2]);
        end
        vec_cnt++;
        if (mem[2][idx(32'h48)] !== 32'h5e17_0048) begin
            err_cnt++;
            $display("FAIL overflow_dropped: sram %h, required %h", mem[2][idx(32'h48)], 32'h5e17_0048);
        end
    endtask

    initial begin
        rst          = 1'b1;
        start        = '0;
        in_valid     = '0;
        in_last      = '0;
        corrupt_en   = '0;
        corrupt_addr = '0;
        for (int i = 0; i < 3; i++) begin
            base_addr[i] = '0;
            in_data[i]   = '0;
            for (int a = 0; a < 256; a++) mem[i][a] = 32'hc0de_0000 | 32'(a);
        end

        test_reset();
        @(posedge clk); #1;
        test_ignore_idle();
        test_verify_load();
        test_mismatch();
        test_reset_mid_load();
        test_start_while_busy();
        test_no_verify();
        test_wrap();
        test_overflow();

        repeat (3) @(posedge clk);
        vec_cnt++;
        if (exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL pending_writes: %0d expected writes never seen, required 0", exp_q.size());
        end
        vec_cnt++;
        if (rd_seen[1] != 0) begin
            err_cnt++;
            $display("FAIL nv_reads: %0d SRAM reads without verify, required 0", rd_seen[1]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
